ram_port_arbiter: RTL

Two-requester arbiter that shares one 64x8 RAM between a requester A and a requester B. It drives the RAM's single write port and its asynchronous read port. At most one access is granted per cycle, using round-robin with a configurable burst allowance. Read data is returned registered, one cycle after grant. It sits between two client engines (e.g. a capture engine and a readback engine) and the RAM instance.

---
 rtl/ram_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for one single-write-port / async-read RAM.
// Round-robin with a burst allowance; read data returned registered one cycle after grant.
module ram_port_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 8,
  parameter int BURST_MAX = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr_write,
  output logic [DW-1:0] ram_data_write,
  output logic [AW-1:0] ram_addr_read,
  input  logic [DW-1:0] ram_data_read
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_a, gnt_b;
  logic [1:0]    gnt_v, we_v, rsp_valid;
  logic [DW-1:0] rsp_rdata [2];

  // Grant decision and owner/burst-count update.
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!reset) begin
      if (a_req && b_req) begin
        if (cnt_q < CNT_MAX) begin
          gnt_a = (owner_q == OWN_A);
          gnt_b = (owner_q == OWN_B);
        end else begin
          gnt_a = (owner_q == OWN_B);
          gnt_b = (owner_q == OWN_A);
        end
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
      if (gnt_a || gnt_b) begin
        if ((gnt_a && owner_q == OWN_A) || (gnt_b && owner_q == OWN_B)) begin
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CW'(1);
        end else begin
          owner_d = gnt_a ? OWN_A : OWN_B;
          cnt_d   = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_B;
      cnt_q   <= CNT_MAX;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ram_we         = 1'b0;
    ram_addr_write = '0;
    ram_addr_read  = '0;
    ram_data_write = '0;
    if (gnt_a) begin
      ram_we         = a_we;
      ram_addr_write = a_addr;
      ram_addr_read  = a_addr;
      ram_data_write = a_wdata;
    end else if (gnt_b) begin
      ram_we         = b_we;
      ram_addr_write = b_addr;
      ram_addr_read  = b_addr;
      ram_data_write = b_wdata;
    end
  end

  assign gnt_v = {gnt_b, gnt_a};
  assign we_v  = {b_we, a_we};

  // One response register pair per requester: index 0 = A, 1 = B.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_rsp
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= gnt_v[gi] && !we_v[gi];
        if (gnt_v[gi] && !we_v[gi]) rdata_q <= ram_data_read;
      end
    end

    assign rsp_valid[gi] = rvalid_q;
    assign rsp_rdata[gi] = rdata_q;
  end

  assign a_gnt    = gnt_a;
  assign b_gnt    = gnt_b;
  // A response still in flight when reset rises is dropped, not presented.
  assign a_rvalid = rsp_valid[0] && !reset;
  assign b_rvalid = rsp_valid[1] && !reset;
  assign a_rdata  = rsp_rdata[0];
  assign b_rdata  = rsp_rdata[1];

endmodule
